sys_ctrl_fsm: RTL and testbench

Command sequencer between the UART RX/TX byte path and the register file / ALU datapath. It parses framed command bytes and turns them into register-file write/read strobes and ALU operations. It returns read data and ALU results as bytes to the TX FIFO. It is the only master of the register file's WrEn/RdEn/Address/WrData bus.

---
 rtl/sys_ctrl_pkg.sv | 28 ++
 rtl/sys_ctrl_fsm.sv | 167 ++++++++++++++++
 tb/tb_sys_ctrl_fsm.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sys_ctrl_pkg.sv
// Shared command codes, operand addresses and state encoding for the
// UART-to-register-file/ALU command sequencer.
package sys_ctrl_pkg;

   localparam logic [7:0] CMD_WR      = 8'hAA;
   localparam logic [7:0] CMD_RD      = 8'hBB;
   localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
   localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

   // REG0/REG1 hold the ALU operands.
   localparam int unsigned OPA_ADDR = 0;
   localparam int unsigned OPB_ADDR = 1;

   typedef enum logic [3:0] {
      IDLE,
      WR_ADDR,
      WR_DATA,
      RD_ADDR,
      RD_WAIT,
      OP_A,
      OP_B,
      ALU_FUN_S,
      ALU_WAIT,
      TX_LO,
      TX_HI
   } state_t;

endpackage

// File: rtl/sys_ctrl_fsm.sv
// Command sequencer: parses framed RX bytes into register-file and ALU
// operations and returns read data / ALU results as bytes to the TX FIFO.
module sys_ctrl_fsm
   import sys_ctrl_pkg::*;
#(
   parameter int D_WIDTH   = 8,
   parameter int ADDRESS   = 4,
   parameter int FUN_WIDTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [D_WIDTH-1:0]     RX_P_DATA,
   input  logic                   RX_D_VLD,
   input  logic [D_WIDTH-1:0]     RdData,
   input  logic                   RD_DATA_VALID,
   input  logic [2*D_WIDTH-1:0]   ALU_OUT,
   input  logic                   OUT_VALID,
   input  logic                   FIFO_FULL,
   output logic                   WrEn,
   output logic                   RdEn,
   output logic [ADDRESS-1:0]     Address,
   output logic [D_WIDTH-1:0]     WrData,
   output logic                   ALU_EN,
   output logic [FUN_WIDTH-1:0]   ALU_FUN,
   output logic                   CLK_EN,
   output logic [D_WIDTH-1:0]     TX_P_DATA,
   output logic                   TX_D_VLD
);

   state_t                 r_state;
   logic [ADDRESS-1:0]     r_wr_addr;
   logic [2*D_WIDTH-1:0]   r_result;
   logic                   r_send_hi;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_wr_addr <= '0;
         r_result  <= '0;
         r_send_hi <= 1'b0;
         WrEn      <= 1'b0;
         RdEn      <= 1'b0;
         Address   <= '0;
         WrData    <= '0;
         ALU_EN    <= 1'b0;
         ALU_FUN   <= '0;
         CLK_EN    <= 1'b0;
         TX_P_DATA <= '0;
         TX_D_VLD  <= 1'b0;
      end else begin
         // NOTE: strobes default low here so any state that raises one holds
         // it for exactly one cycle; non-blocking updates mean every branch
         // below sees the pre-edge register values.
         WrEn     <= 1'b0;
         RdEn     <= 1'b0;
         ALU_EN   <= 1'b0;
         TX_D_VLD <= 1'b0;

         case (r_state)
            IDLE: begin
               if (RX_D_VLD) begin
                  case (RX_P_DATA)
                     CMD_WR:      r_state <= WR_ADDR;
                     CMD_RD:      r_state <= RD_ADDR;
                     CMD_ALU_OP:  r_state <= OP_A;
                     CMD_ALU_NOP: begin
                        r_state <= ALU_FUN_S;
                        CLK_EN  <= 1'b1;
                     end
                     default:     r_state <= IDLE;
                  endcase
               end
            end

            WR_ADDR: begin
               if (RX_D_VLD) begin
                  r_wr_addr <= RX_P_DATA[ADDRESS-1:0];
                  r_state   <= WR_DATA;
               end
            end

            WR_DATA: begin
               if (RX_D_VLD) begin
                  WrEn    <= 1'b1;
                  Address <= r_wr_addr;
                  WrData  <= RX_P_DATA;
                  r_state <= IDLE;
               end
            end

            RD_ADDR: begin
               if (RX_D_VLD) begin
                  RdEn    <= 1'b1;
                  Address <= RX_P_DATA[ADDRESS-1:0];
                  r_state <= RD_WAIT;
               end
            end

            RD_WAIT: begin
               if (RD_DATA_VALID) begin
                  r_result  <= {{D_WIDTH{1'b0}}, RdData};
                  r_send_hi <= 1'b0;
                  r_state   <= TX_LO;
               end
            end

            OP_A: begin
               if (RX_D_VLD) begin
                  WrEn    <= 1'b1;
                  Address <= ADDRESS'(OPA_ADDR);
                  WrData  <= RX_P_DATA;
                  r_state <= OP_B;
               end
            end

            OP_B: begin
               if (RX_D_VLD) begin
                  WrEn    <= 1'b1;
                  Address <= ADDRESS'(OPB_ADDR);
                  WrData  <= RX_P_DATA;
                  CLK_EN  <= 1'b1;
                  r_state <= ALU_FUN_S;
               end
            end

            ALU_FUN_S: begin
               if (RX_D_VLD) begin
                  ALU_FUN <= RX_P_DATA[FUN_WIDTH-1:0];
                  ALU_EN  <= 1'b1;
                  r_state <= ALU_WAIT;
               end
            end

            // The ALU clock stays enabled until its result is safely captured.
            ALU_WAIT: begin
               if (OUT_VALID) begin
                  r_result  <= ALU_OUT;
                  r_send_hi <= 1'b1;
                  CLK_EN    <= 1'b0;
                  r_state   <= TX_LO;
               end
            end

            TX_LO: begin
               if (!FIFO_FULL) begin
                  TX_D_VLD  <= 1'b1;
                  TX_P_DATA <= r_result[D_WIDTH-1:0];
                  r_state   <= r_send_hi ? TX_HI : IDLE;
               end
            end

            TX_HI: begin
               if (!FIFO_FULL) begin
                  TX_D_VLD  <= 1'b1;
                  TX_P_DATA <= r_result[2*D_WIDTH-1:D_WIDTH];
                  r_state   <= IDLE;
               end
            end

            default: r_state <= IDLE;
         endcase
      end
   end

   a_wr_rd_exclusive: assert property (@(posedge clk) disable iff (!rst) !(WrEn && RdEn));

endmodule

// File: tb/tb_sys_ctrl_fsm.sv
// Randomized self-checking bench for sys_ctrl_fsm: a transaction-level model
// predicts register writes, reads, ALU requests and TX bytes per frame.
module tb_sys_ctrl_fsm;

   localparam logic [7:0] C_WR  = 8'hAA;
   localparam logic [7:0] C_RD  = 8'hBB;
   localparam logic [7:0] C_OP  = 8'hCC;
   localparam logic [7:0] C_NOP = 8'hDD;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  RX_P_DATA = '0;
   logic        RX_D_VLD = 1'b0;
   logic [7:0]  RdData;
   logic        RD_DATA_VALID;
   logic [15:0] ALU_OUT;
   logic        OUT_VALID;
   logic        FIFO_FULL;
   logic        WrEn, RdEn, ALU_EN, CLK_EN, TX_D_VLD;
   logic [3:0]  Address, ALU_FUN;
   logic [7:0]  WrData, TX_P_DATA;

   always #5 clk = ~clk;

   sys_ctrl_fsm dut (
      .clk(clk), .rst(rst),
      .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
      .RdData(RdData), .RD_DATA_VALID(RD_DATA_VALID),
      .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID), .FIFO_FULL(FIFO_FULL),
      .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
      .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_EN(CLK_EN),
      .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference behaviour: ALU function table shared by the responder and the model.
   function automatic logic [15:0] alu_ref(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
      case (f)
         4'd0:    return 16'(a) + 16'(b);
         4'd1:    return 16'(a) - 16'(b);
         4'd2:    return 16'(a) * 16'(b);
         4'd3:    return (b == 8'd0) ? 16'h0 : 16'(a / b);
         4'd4:    return {8'h00, a & b};
         4'd5:    return {8'h00, a | b};
         4'd6:    return {8'h00, a ^ b};
         default: return {a, b};
      endcase
   endfunction

   function automatic bit is_cmd(input logic [7:0] b);
      return (b == C_WR) || (b == C_RD) || (b == C_OP) || (b == C_NOP);
   endfunction

   logic [7:0]  ref_mem [16] = '{default: 8'h00};
   logic [7:0]  env_mem [16] = '{default: 8'h00};
   logic [11:0] exp_wr[$], obs_wr[$];
   logic [3:0]  exp_rd[$], obs_rd[$];
   logic [3:0]  exp_alu[$], obs_alu[$];
   logic [7:0]  exp_tx[$], obs_tx[$];

   bit full_force = 0;
   bit full_rand  = 0;
   int alu_lat_force = 0;
   logic full_sampled = 1'b0;

   initial forever begin
      @(posedge clk);
      full_sampled = FIFO_FULL;
   end

   initial begin
      FIFO_FULL = 1'b0;
      forever begin
         @(negedge clk);
         if (full_force)     FIFO_FULL = 1'b1;
         else if (full_rand) FIFO_FULL = ($urandom_range(0, 2) == 0);
         else                FIFO_FULL = 1'b0;
      end
   end

   // Monitor: records every strobe; the environment register file follows DUT writes.
   initial forever begin
      @(negedge clk);
      if (WrEn) begin
         obs_wr.push_back({Address, WrData});
         env_mem[Address] = WrData;
      end
      if (RdEn)     obs_rd.push_back(Address);
      if (ALU_EN)   obs_alu.push_back(ALU_FUN);
      if (TX_D_VLD) begin
         obs_tx.push_back(TX_P_DATA);
         check("tx_while_full", 32'(full_sampled), 32'h0);
      end
      if (WrEn && RdEn) check("wr_rd_excl", 32'h1, 32'h0);
   end

   // Register-file read responder: data valid one cycle after RdEn.
   initial begin
      logic [3:0] ra;
      RD_DATA_VALID = 1'b0;
      RdData = '0;
      forever begin
         @(negedge clk);
         if (RdEn) begin
            ra = Address;
            @(negedge clk);
            RdData = env_mem[ra];
            RD_DATA_VALID = 1'b1;
            @(negedge clk);
            RD_DATA_VALID = 1'b0;
         end
      end
   end

   // ALU responder with variable latency.
   initial begin
      logic [3:0] fa;
      int lat;
      OUT_VALID = 1'b0;
      ALU_OUT = '0;
      forever begin
         @(negedge clk);
         if (ALU_EN) begin
            fa  = ALU_FUN;
            lat = (alu_lat_force != 0) ? alu_lat_force : int'($urandom_range(1, 4));
            repeat (lat) @(negedge clk);
            ALU_OUT = alu_ref(fa, env_mem[0], env_mem[1]);
            OUT_VALID = 1'b1;
            @(negedge clk);
            OUT_VALID = 1'b0;
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      RX_P_DATA = b;
      RX_D_VLD  = 1'b1;
      @(negedge clk);
      RX_D_VLD  = 1'b0;
      RX_P_DATA = 8'($urandom);
   endtask

   task automatic do_write(input logic [7:0] a, input logic [7:0] d);
      exp_wr.push_back({a[3:0], d});
      ref_mem[a[3:0]] = d;
      send_byte(C_WR);
      send_byte(a);
      send_byte(d);
   endtask

   task automatic do_read(input logic [7:0] a, input bit drop, input logic [7:0] db);
      exp_rd.push_back(a[3:0]);
      exp_tx.push_back(ref_mem[a[3:0]]);
      send_byte(C_RD);
      send_byte(a);
      if (drop) send_byte(db);
   endtask

   task automatic model_alu(input logic [7:0] fb);
      logic [15:0] r;
      exp_alu.push_back(fb[3:0]);
      r = alu_ref(fb[3:0], ref_mem[0], ref_mem[1]);
      exp_tx.push_back(r[7:0]);
      exp_tx.push_back(r[15:8]);
   endtask

   task automatic do_alu_op(input logic [7:0] x, input logic [7:0] y, input logic [7:0] fb,
                            input bit drop, input logic [7:0] db);
      exp_wr.push_back({4'd0, x});
      exp_wr.push_back({4'd1, y});
      ref_mem[0] = x;
      ref_mem[1] = y;
      model_alu(fb);
      send_byte(C_OP);
      send_byte(x);
      send_byte(y);
      send_byte(fb);
      if (drop) send_byte(db);
   endtask

   task automatic do_alu_nop(input logic [7:0] fb, input bit drop, input logic [7:0] db);
      model_alu(fb);
      send_byte(C_NOP);
      send_byte(fb);
      if (drop) send_byte(db);
   endtask

   task automatic wait_done();
      int budget = 400;
      while (obs_tx.size() < exp_tx.size() && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic compare_clear(input string tag);
      check({tag, ":wr_n"}, 32'(obs_wr.size()), 32'(exp_wr.size()));
      for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++)
         check({tag, ":wr"}, 32'(obs_wr[i]), 32'(exp_wr[i]));
      check({tag, ":rd_n"}, 32'(obs_rd.size()), 32'(exp_rd.size()));
      for (int i = 0; i < exp_rd.size() && i < obs_rd.size(); i++)
         check({tag, ":rd"}, 32'(obs_rd[i]), 32'(exp_rd[i]));
      check({tag, ":alu_n"}, 32'(obs_alu.size()), 32'(exp_alu.size()));
      for (int i = 0; i < exp_alu.size() && i < obs_alu.size(); i++)
         check({tag, ":alu_fun"}, 32'(obs_alu[i]), 32'(exp_alu[i]));
      check({tag, ":tx_n"}, 32'(obs_tx.size()), 32'(exp_tx.size()));
      for (int i = 0; i < exp_tx.size() && i < obs_tx.size(); i++)
         check({tag, ":tx"}, 32'(obs_tx[i]), 32'(exp_tx[i]));
      exp_wr.delete();  obs_wr.delete();
      exp_rd.delete();  obs_rd.delete();
      exp_alu.delete(); obs_alu.delete();
      exp_tx.delete();  obs_tx.delete();
   endtask

   function automatic logic [31:0] all_outs();
      return 32'({WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_EN, TX_P_DATA, TX_D_VLD});
   endfunction

   initial begin
      int budget;
      int kind;
      logic [7:0] a, d, x, y, g, db;
      bit drop;

      repeat (2) @(negedge clk);
      check("reset_outputs", all_outs(), 32'h0);
      rst = 1'b1;

      // Write frame: one WrEn, next cycle after the data byte.
      do_write(8'h05, 8'h3C);
      check("wr_latency", 32'(WrEn), 32'h1);
      check("wr_addr", 32'(Address), 32'h5);
      check("wr_data", 32'(WrData), 32'h3C);
      check("wr_no_rden", 32'(RdEn), 32'h0);
      wait_done();
      compare_clear("write");

      // Read frame returns the written byte.
      do_read(8'h05, 1'b0, 8'h00);
      check("rd_latency", 32'(RdEn), 32'h1);
      check("rd_addr", 32'(Address), 32'h5);
      wait_done();
      if (obs_tx.size() > 0) check("rd_byte", 32'(obs_tx[0]), 32'h3C);
      compare_clear("read");

      // ALU with operands: 7 + 3.
      do_alu_op(8'h07, 8'h03, 8'h00, 1'b0, 8'h00);
      check("alu_en_latency", 32'(ALU_EN), 32'h1);
      check("alu_fun", 32'(ALU_FUN), 32'h0);
      check("alu_clk_en", 32'(CLK_EN), 32'h1);
      wait_done();
      if (obs_tx.size() > 1) begin
         check("alu_tx_lo", 32'(obs_tx[0]), 32'h0A);
         check("alu_tx_hi", 32'(obs_tx[1]), 32'h00);
      end
      compare_clear("alu_op");

      // Backpressure: operands 0xE9 * 0x14 = 0x1234, FIFO full across the capture.
      do_write(8'h00, 8'hE9);
      do_write(8'h01, 8'h14);
      wait_done();
      compare_clear("bp_setup");
      full_force = 1;
      model_alu(8'h02);
      send_byte(C_NOP);
      check("bp_clk_en_enter", 32'(CLK_EN), 32'h1);
      send_byte(8'h02);
      check("bp_alu_en", 32'(ALU_EN), 32'h1);
      budget = 100;
      while (CLK_EN && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      check("bp_clk_en_drop", 32'(CLK_EN), 32'h0);
      repeat (5) @(negedge clk);
      check("bp_no_push_full", 32'(obs_tx.size()), 32'h0);
      full_force = 0;
      wait_done();
      if (obs_tx.size() > 1) begin
         check("bp_tx_lo", 32'(obs_tx[0]), 32'h34);
         check("bp_tx_hi", 32'(obs_tx[1]), 32'h12);
      end
      compare_clear("backpressure");

      // Garbage in IDLE, then a command byte landing in ALU_WAIT.
      send_byte(8'h55);
      wait_done();
      compare_clear("garbage");
      alu_lat_force = 6;
      do_alu_nop(8'h01, 1'b1, C_RD);
      wait_done();
      compare_clear("overlap");
      alu_lat_force = 0;
      do_write(8'h0A, 8'h5A);
      wait_done();
      compare_clear("after_overlap");

      // Reset in the middle of a write frame.
      send_byte(C_WR);
      send_byte(8'h05);
      rst = 1'b0;
      #1;
      check("midframe_reset_outputs", all_outs(), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      send_byte(8'h11);
      check("midframe_no_wren", 32'(WrEn), 32'h0);
      wait_done();
      compare_clear("midframe_reset");

      // Randomized frames with FIFO backpressure and dropped bytes.
      full_rand = 1;
      for (int f = 0; f < 80; f++) begin
         kind = $urandom_range(0, 4);
         a    = 8'($urandom);
         d    = 8'($urandom);
         x    = 8'($urandom);
         y    = 8'($urandom);
         db   = 8'($urandom);
         drop = 1'($urandom_range(0, 1));
         case (kind)
            0: do_write(a, d);
            1: do_read(a, drop, db);
            2: do_alu_op(x, y, d, drop, db);
            3: do_alu_nop(d, drop, db);
            default: begin
               g = 8'($urandom);
               while (is_cmd(g)) g = 8'($urandom);
               send_byte(g);
            end
         endcase
         wait_done();
         compare_clear("random");
      end
      full_rand = 0;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
